// File: rtl/phy_rx_pkg.sv
// Shared constants and FSM encoding for the two-lane PHY receive path.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SKEW    = 2'd1,
    ALIGNED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/lane_lock.sv
// Per-lane comma qualifier: locks after SYNC_COUNT consecutive commas and
// drops lock after LOSS_COUNT consecutive idle cycles or a controller clear.
module lane_lock
  import phy_rx_pkg::*;
#(
  parameter int SYNC_COUNT = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       clear,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       locked
);

  localparam int CW = $clog2(SYNC_COUNT + 1);
  localparam int IW = $clog2(LOSS_COUNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          locked_q, locked_d;
  logic          is_comma;

  assign is_comma = valid_in && (data_in == COMMA_BC);
  assign locked   = locked_q;

  // Clear wins over any lock event in the same cycle; a dropped lock must re-qualify from zero.
  always_comb begin
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    locked_d = locked_q;
    if (clear) begin
      cnt_d    = {CW{1'b0}};
      idle_d   = {IW{1'b0}};
      locked_d = 1'b0;
    end else if (locked_q) begin
      if (valid_in) begin
        idle_d = {IW{1'b0}};
      end else if (idle_q == IW'(LOSS_COUNT - 1)) begin
        idle_d   = {IW{1'b0}};
        cnt_d    = {CW{1'b0}};
        locked_d = 1'b0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = {IW{1'b0}};
      if (is_comma) begin
        if (cnt_q == CW'(SYNC_COUNT - 1)) begin
          cnt_d    = CW'(SYNC_COUNT);
          locked_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (valid_in) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt_q    <= {CW{1'b0}};
      idle_q   <= {IW{1'b0}};
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/phy_rx_lane_sync.sv
// Two-lane sync/deskew controller: lock FSM, early-lane delay line, output gating.
// Optional saturating loss counter enabled by PHY_RX_LANE_SYNC_STATS_EN.
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter int SYNC_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int SKEW_MAX   = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       sync_ok,
  output logic [2:0] skew,
  output logic       early_lane,
  output logic       skew_err
`ifdef PHY_RX_LANE_SYNC_STATS_EN
  ,
  output logic [7:0] loss_count
`endif
);

  sync_state_e state_q, state_d;
  logic [2:0]  skew_cnt_q, skew_cnt_d;
  logic [2:0]  skew_q, skew_d;
  logic        early_sel_q, early_sel_d;
  logic        early_lane_q, early_lane_d;
  logic        skew_err_q, skew_err_d;
  logic        sync_ok_q, sync_ok_d;
  logic [7:0]  data_out_q [2];
  logic [7:0]  data_out_d [2];
  logic [1:0]  valid_out_q, valid_out_d;
  logic [8:0]  sr_q [2][SKEW_MAX];
  logic [8:0]  sr_d [2][SKEW_MAX];
  logic [8:0]  lane_in [2];
  logic [8:0]  tap [2];
  logic        locked_0, locked_1, late_locked, clear;

  lane_lock #(.SYNC_COUNT(SYNC_COUNT), .LOSS_COUNT(LOSS_COUNT)) u_lock_0 (
    .clk_4f(clk_4f), .reset(reset), .clear(clear),
    .valid_in(valid_in_0), .data_in(data_in_0), .locked(locked_0)
  );

  lane_lock #(.SYNC_COUNT(SYNC_COUNT), .LOSS_COUNT(LOSS_COUNT)) u_lock_1 (
    .clk_4f(clk_4f), .reset(reset), .clear(clear),
    .valid_in(valid_in_1), .data_in(data_in_1), .locked(locked_1)
  );

  assign lane_in[0]  = {valid_in_0, data_in_0};
  assign lane_in[1]  = {valid_in_1, data_in_1};
  assign late_locked = early_sel_q ? locked_0 : locked_1;

  // early_sel tracks the candidate lead lane; the visible skew/early_lane only move on entry to ALIGNED.
  always_comb begin
    state_d      = state_q;
    skew_cnt_d   = skew_cnt_q;
    early_sel_d  = early_sel_q;
    skew_d       = skew_q;
    early_lane_d = early_lane_q;
    skew_err_d   = 1'b0;
    clear        = 1'b0;
    case (state_q)
      SEARCH: begin
        if (locked_0 && locked_1) begin
          skew_d       = 3'd0;
          early_lane_d = 1'b0;
          state_d      = ALIGNED;
        end else if (locked_0 || locked_1) begin
          early_sel_d = locked_1;
          skew_cnt_d  = 3'd1;
          state_d     = SKEW;
        end else begin
          state_d = SEARCH;
        end
      end
      SKEW: begin
        if (late_locked) begin
          skew_d       = skew_cnt_q;
          early_lane_d = early_sel_q;
          state_d      = ALIGNED;
        end else if (skew_cnt_q == 3'(SKEW_MAX)) begin
          skew_err_d = 1'b1;
          clear      = 1'b1;
          state_d    = SEARCH;
        end else begin
          skew_cnt_d = skew_cnt_q + 3'd1;
        end
      end
      ALIGNED: begin
        if (!locked_0 || !locked_1) begin
          clear   = 1'b1;
          state_d = SEARCH;
        end else begin
          state_d = ALIGNED;
        end
      end
      default: state_d = SEARCH;
    endcase
    sync_ok_d = (state_d == ALIGNED);
  end

  // Both lanes shift every cycle; only the early lane ever reads a non-zero tap.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      sr_d[l][0] = lane_in[l];
      for (int k = 1; k < SKEW_MAX; k++) sr_d[l][k] = sr_q[l][k-1];
      tap[l] = lane_in[l];
      for (int k = 0; k < SKEW_MAX; k++)
        tap[l] = (early_lane_q == 1'(l) && skew_q == 3'(k + 1)) ? sr_q[l][k] : tap[l];
      data_out_d[l] = tap[l][7:0];
    end
    valid_out_d[0] = (state_q == ALIGNED) && (state_d == ALIGNED) &&
                     tap[0][8] && tap[1][8] &&
                     (tap[0][7:0] != COMMA_BC) && (tap[1][7:0] != COMMA_BC);
    valid_out_d[1] = valid_out_d[0];
  end

`ifdef PHY_RX_LANE_SYNC_STATS_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (((state_q == ALIGNED && state_d == SEARCH) || skew_err_d) && loss_q != 8'hFF) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) loss_q <= 8'd0;
    else       loss_q <= loss_d;
  end

  assign loss_count = loss_q;
`endif

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q      <= SEARCH;
      skew_cnt_q   <= 3'd0;
      skew_q       <= 3'd0;
      early_sel_q  <= 1'b0;
      early_lane_q <= 1'b0;
      skew_err_q   <= 1'b0;
      sync_ok_q    <= 1'b0;
      valid_out_q  <= 2'b00;
      for (int l = 0; l < 2; l++) begin
        data_out_q[l] <= 8'd0;
        for (int k = 0; k < SKEW_MAX; k++) sr_q[l][k] <= 9'd0;
      end
    end else begin
      state_q      <= state_d;
      skew_cnt_q   <= skew_cnt_d;
      skew_q       <= skew_d;
      early_sel_q  <= early_sel_d;
      early_lane_q <= early_lane_d;
      skew_err_q   <= skew_err_d;
      sync_ok_q    <= sync_ok_d;
      valid_out_q  <= valid_out_d;
      for (int l = 0; l < 2; l++) begin
        data_out_q[l] <= data_out_d[l];
        for (int k = 0; k < SKEW_MAX; k++) sr_q[l][k] <= sr_d[l][k];
      end
    end
  end

  assign data_out_0  = data_out_q[0];
  assign data_out_1  = data_out_q[1];
  assign valid_out_0 = valid_out_q[0];
  assign valid_out_1 = valid_out_q[1];
  assign sync_ok     = sync_ok_q;
  assign skew        = skew_q;
  assign early_lane  = early_lane_q;
  assign skew_err    = skew_err_q;

endmodule

// File: doc/phy_rx_lane_sync.md
# phy_rx_lane_sync

Lane synchronisation and deskew controller for the two-lane PHY receiver. Sits between the two serial-to-parallel converters and the two 8b-to-32b converters in the `clk_4f` domain. It performs three jobs:
- qualifies each lane by counting consecutive 0xBC comma bytes;
- measures the skew between the lanes and delays the earlier lane to remove it;
- gates the byte-valid strobes so downstream stages see only aligned, non-idle data.

## Interface
Parameters:
- `SYNC_COUNT`, 4: consecutive valid 0xBC bytes a lane needs to lock.
- `LOSS_COUNT`, 4: consecutive cycles with `valid_in_x`=0 that drop lock on a locked lane.
- `SKEW_MAX`, 3: maximum correctable skew in `clk_4f` cycles; range 1..7.

Ports:
- `clk_4f`  in  1: byte clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `data_in_0`, `data_in_1`  in  8: parallel bytes from each lane.
- `valid_in_0`, `valid_in_1`  in  1: byte strobes from each lane.
- `data_out_0`, `data_out_1`  out  8: deskewed bytes; reset 0.
- `valid_out_0`, `valid_out_1`  out  1: aligned data strobes; reset 0.
- `sync_ok`  out  1: high in ALIGNED; reset 0.
- `skew`  out  3: measured skew value; reset 0.
- `early_lane`  out  1: lane delayed by `skew`; reset 0.
- `skew_err`  out  1: one-cycle pulse on skew timeout; reset 0.
- `loss_count`  out  8: only with `PHY_RX_LANE_SYNC_STATS_EN`; reset 0.

## Operation
Per-lane lock logic (lane `x`):
- `cnt` increments on `valid_in_x && data_in_x==8'hBC`.
- `cnt` clears on `valid_in_x && data_in_x!=8'hBC` while unlocked.
- `cnt` holds when `valid_in_x`=0.
- `locked_x` sets in the cycle `cnt` reaches `SYNC_COUNT`.
- Once locked, `locked_x` clears only when either:
  - the idle counter reaches `LOSS_COUNT` consecutive cycles of `valid_in_x`=0; or
  - the controller pulses `clear` (clear also zeroes `cnt`).

Controller FSM, states SEARCH, SKEW and ALIGNED:
- **SEARCH**:
  - Both lanes lock in the same cycle: `skew`=0, go to ALIGNED.
  - One lane locks: set `early_lane` to that lane, `skew_cnt`=1, go to SKEW.
- **SKEW**:
  - Late lane locks: `skew`=`skew_cnt`, go to ALIGNED.
  - Else if `skew_cnt`==`SKEW_MAX`: pulse `skew_err`, pulse `clear`, go to SEARCH.
  - Else `skew_cnt`++.
- **ALIGNED**: either `locked_x` falls -> pulse `clear`, go to SEARCH.

Deskew:
- The early lane's {valid, data} passes through a `SKEW_MAX`-deep shift register, tapped at `skew`. Tap 0 is the direct path.
- The late lane is never delayed.

Output gating:
- `valid_out_x` = ALIGNED && both aligned valids high && both aligned bytes != 0xBC.
- Idle commas never reach the 8b-to-32b stage. A pair with one comma and one data byte is a lane error and is dropped (no valid).
- `data_out_x` always carries the aligned byte.

Reset and re-sync:
- `reset` at any point returns all state, counters, the shift register and all outputs to their reset values on the next edge.
- Lane data in flight is discarded. No partial output after reset.
- `skew` and `early_lane` hold their last values in SEARCH and SKEW, and are updated only on entry to ALIGNED.

## Timing
- Total data-path latency = 1 + `skew` cycles (early lane) and 1 cycle (late lane): one output register stage after the tap mux.
- `locked_x` rises 1 cycle after the `SYNC_COUNT`-th comma is sampled.
- `sync_ok` rises 1 cycle after the FSM decision.
- First possible `valid_out` is on the cycle after `sync_ok` rises.
- `skew_err` and `clear` pulses are exactly 1 cycle.
- After `clear`, both lanes restart counting from 0 on the next cycle.
- A lock event coinciding with `clear` is ignored.

## Configuration
`PHY_RX_LANE_SYNC_STATS_EN`:
- **Defined**: adds the `loss_count` port, an 8-bit saturating counter (saturates at 255).
  - Increments on each ALIGNED->SEARCH transition and each `skew_err`.
  - Cleared only by `reset`.
- **Undefined**: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `phy_rx_pkg` holds:
  - the comma constant (`COMMA_BC` = 8'hBC);
  - the FSM state encoding (SEARCH=2'd0, SKEW=2'd1, ALIGNED=2'd2).
- One sub-module, `lane_lock`, instantiated twice. It contains the comma counter, idle counter, `locked` flag and `clear` input.
- The FSM, skew shift register and output gating live in the top module.

## Test plan
- Both lanes send 4 commas on the same cycles, then data 0x11/0x22 -> `sync_ok`=1 and `skew`=0; `valid_out_0/1`=1 with 0x11/0x22 on the same cycle.
- Lane 1 lags lane 0 by 2 cycles -> `early_lane`=0 and `skew`=2; lane 0 data delayed 2 cycles; output bytes paired on the same cycle.
- Lane 1 lags by 4 cycles with `SKEW_MAX`=3 -> `skew_err` pulses once; FSM returns to SEARCH; both locks cleared.
- Lane 0 sends 3 commas, 0x55, then 4 commas -> lock occurs only after the second comma run.
- In ALIGNED, drop `valid_in_1` for 4 cycles -> `sync_ok` falls; `valid_out` stays low until re-lock; `loss_count`=1 with the macro defined.
- Assert `reset` in ALIGNED mid-data -> next cycle all outputs are 0 and the FSM is in SEARCH.
